// File: rtl/regfile_param.sv
// Parametrised integer register file with power-on clear sequencer and a
// per-register pending scoreboard for RAW hazard detection.
module regfile_param #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic [NRD-1:0]      busy
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              init_done_q, init_done_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];

  // Next-state: clear sequence in INIT, writes and scoreboard updates in READY
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    pending_d   = pending_q;
    mem_d       = mem_q;
    case (state_q)
      INIT: begin
        mem_d[clr_cnt_q] = '0;
        if (clr_cnt_q == LAST_IDX) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      READY: begin
        if (we && !((ZERO_REG != 0) && (wa == '0))) begin
          mem_d[wa] = wd;
        end
        // Clear first so a same-cycle issue to the same index wins
        if (we) begin
          pending_d[wa] = 1'b0;
        end
        if (issue_valid && !((ZERO_REG != 0) && (issue_rd == '0))) begin
          pending_d[issue_rd] = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Control state with synchronous reset restarting the clear sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      pending_q   <= pending_d;
    end
  end

  // Storage array; not reset, the INIT sequence zeroes it instead
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

  assign init_done = init_done_q;

  // Combinational read ports and busy flags, forced to 0 outside READY
  always_comb begin
    logic [AW-1:0] addr;
    logic          zero_hit;
    logic          byp_hit;
    rd       = '0;
    busy     = '0;
    addr     = '0;
    zero_hit = 1'b0;
    byp_hit  = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      addr     = ra[i*AW +: AW];
      zero_hit = (ZERO_REG != 0) && (addr == '0);
      byp_hit  = (BYPASS != 0) && we && (wa == addr);
      if (state_q == READY) begin
        if (zero_hit) begin
          rd[i*XLEN +: XLEN] = '0;
        end else if (byp_hit) begin
          rd[i*XLEN +: XLEN] = wd;
        end else begin
          rd[i*XLEN +: XLEN] = mem_q[addr];
        end
        busy[i] = pending_q[addr] && !zero_hit && !byp_hit;
      end
    end
  end

endmodule
